// File: rtl/relogio_pkg.sv
// Shared definitions for the clock's push-button front end: repeat FSM
// states, 50 MHz default timing and pad polarity.
package relogio_pkg;

    typedef enum logic [1:0] {
        SOLTO  = 2'b00,
        ESPERA = 2'b01,
        REPETE = 2'b10
    } rep_state_t;

    localparam int DEB_CYC_DEF    = 250000;
    localparam int REP_DELAY_DEF  = 25000000;
    localparam int REP_PERIOD_DEF = 5000000;
    localparam int ACTIVE_LOW_DEF = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/canal_botao.sv
// One button channel: two-flop synchroniser, debounce, registered press pulse
// and, when REPEAT_EN is set, hold-to-repeat pulses.
module canal_botao
    import relogio_pkg::*;
#(
    parameter int DEB_CYC    = DEB_CYC_DEF,
    parameter int REP_DELAY  = REP_DELAY_DEF,
    parameter int REP_PERIOD = REP_PERIOD_DEF,
    parameter bit REPEAT_EN  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed,
    output logic nivel,
    output logic pulse
);

    localparam int DW = cnt_w(DEB_CYC);
    localparam int TW = cnt_w(max_int(REP_DELAY, REP_PERIOD));
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYC - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REP_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REP_PERIOD - 1);

    logic          sync1_q, sync2_q;
    logic          estavel_q, estavel_d;
    logic          prev_q;
    logic [DW-1:0] cnt_q, cnt_d;
    rep_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pulse_q, pulse_d;
    logic          rise;

    assign rise  = estavel_q & ~prev_q;
    assign nivel = estavel_q;
    assign pulse = pulse_q;

    // Any sample agreeing with the accepted level restarts the count.
    always_comb begin
        estavel_d = estavel_q;
        cnt_d     = '0;
        if (sync2_q != estavel_q) begin
            if (cnt_q == DEB_LAST) begin
                estavel_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Release takes priority over any timer match.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        if (!estavel_q) begin
            state_d = SOLTO;
            timer_d = '0;
        end else begin
            case (state_q)
                SOLTO: begin
                    if (rise) begin
                        pulse_d = 1'b1;
                        timer_d = '0;
                        if (REPEAT_EN) state_d = ESPERA;
                    end
                end
                ESPERA: begin
                    if (timer_q == DELAY_LAST) begin
                        pulse_d = 1'b1;
                        state_d = REPETE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                REPETE: begin
                    if (timer_q == PERIOD_LAST) begin
                        pulse_d = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SOLTO;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            estavel_q <= 1'b0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= SOLTO;
            timer_q   <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync1_q   <= pressed;
            sync2_q   <= sync1_q;
            estavel_q <= estavel_d;
            prev_q    <= estavel_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            pulse_q   <= pulse_d;
        end
    end

endmodule

// File: rtl/condiciona_botoes.sv
// Button front end for the clock: normalises pad polarity and feeds the mode
// button (no repeat) and the increment button (with repeat) channels.
module condiciona_botoes
    import relogio_pkg::*;
#(
    parameter int DEB_CYC    = DEB_CYC_DEF,
    parameter int REP_DELAY  = REP_DELAY_DEF,
    parameter int REP_PERIOD = REP_PERIOD_DEF,
    parameter int ACTIVE_LOW = ACTIVE_LOW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0_raw,
    input  logic btn1_raw,
    output logic btn0,
    output logic btn1,
    output logic btn0_nivel,
    output logic btn1_nivel
);

    localparam logic POL = (ACTIVE_LOW != 0);

    logic pressed0, pressed1;

    assign pressed0 = btn0_raw ^ POL;
    assign pressed1 = btn1_raw ^ POL;

    canal_botao #(
        .DEB_CYC   (DEB_CYC),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD),
        .REPEAT_EN (1'b0)
    ) u_canal0 (
        .clk    (clk),
        .rst    (rst),
        .pressed(pressed0),
        .nivel  (btn0_nivel),
        .pulse  (btn0)
    );

    canal_botao #(
        .DEB_CYC   (DEB_CYC),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD),
        .REPEAT_EN (1'b1)
    ) u_canal1 (
        .clk    (clk),
        .rst    (rst),
        .pressed(pressed1),
        .nivel  (btn1_nivel),
        .pulse  (btn1)
    );

endmodule

// File: tb/tb_condiciona_botoes.sv
// Bench for condiciona_botoes: expected pulse cycles are queued as stimulus is
// driven and matched by a monitor as the pulses appear.
module tb_condiciona_botoes;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn0_raw = 1'b1;
    logic btn1_raw = 1'b1;
    logic btn0, btn1, btn0_nivel, btn1_nivel;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int q0[$];
    int q1[$];
    int e0, e1;

    always #5 clk = ~clk;

    condiciona_botoes #(
        .DEB_CYC   (DEB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn0_raw  (btn0_raw),
        .btn1_raw  (btn1_raw),
        .btn0      (btn0),
        .btn1      (btn1),
        .btn0_nivel(btn0_nivel),
        .btn1_nivel(btn1_nivel)
    );

    // Scoreboard: every observed pulse must match the head of its queue.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (btn0 === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL btn0_pulse: pulse at cycle %0d, required none", cyc);
            end else begin
                e0 = q0.pop_front();
                if (cyc !== e0) begin
                    bad++;
                    $display("FAIL btn0_pulse: pulse at cycle %0d, required cycle %0d", cyc, e0);
                end else begin
                    $display("btn0 pulse at cycle %0d ok", cyc);
                end
            end
        end
        if (btn1 === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL btn1_pulse: pulse at cycle %0d, required none", cyc);
            end else begin
                e1 = q1.pop_front();
                if (cyc !== e1) begin
                    bad++;
                    $display("FAIL btn1_pulse: pulse at cycle %0d, required cycle %0d", cyc, e1);
                end else begin
                    $display("btn1 pulse at cycle %0d ok", cyc);
                end
            end
        end
    end

    // Press pulse at 'first', then RD later, then every RP, while <= 'last'.
    task automatic push_rep(input int first, input int last);
        int t;
        int step;
        t = first;
        step = RD;
        while (t <= last) begin
            q1.push_back(t);
            t += step;
            step = RP;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_queues_empty(input string name);
        total++;
        if (q0.size() !== 0 || q1.size() !== 0) begin
            bad++;
            $display("FAIL %s_pending: pending btn0=%0d btn1=%0d, required 0 0",
                     name, q0.size(), q1.size());
        end else begin
            $display("%s: all expected pulses seen", name);
        end
    endtask

    task automatic test_reset();
        for (int j = 1; j <= 53; j++) begin
            @(negedge clk);
            if (j == 3) rst = 1'b1;
            total++;
            if ({btn0, btn1, btn0_nivel, btn1_nivel} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs: cycle %0d outputs %b, required 0000", cyc,
                         {btn0, btn1, btn0_nivel, btn1_nivel});
            end
        end
        $display("reset: outputs checked over 53 cycles");
    endtask

    task automatic test_press0();
        int c;
        logic exp_lvl;
        c = cyc;
        btn0_raw = 1'b0;
        q0.push_back(c + LAT);
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            exp_lvl = (j >= DEB + 2);
            total++;
            if (btn0_nivel !== exp_lvl) begin
                bad++;
                $display("FAIL press0_nivel: cycle %0d nivel %b, required %b", cyc, btn0_nivel, exp_lvl);
            end
        end
        btn0_raw = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            exp_lvl = (j < DEB + 2);
            total++;
            if (btn0_nivel !== exp_lvl) begin
                bad++;
                $display("FAIL release0_nivel: cycle %0d nivel %b, required %b", cyc, btn0_nivel, exp_lvl);
            end
        end
        test_queues_empty("press0");
    endtask

    task automatic test_bounce1();
        int c;
        c = cyc;
        btn1_raw = 1'b0; idle(3);
        btn1_raw = 1'b1; idle(1);
        btn1_raw = 1'b0; idle(2);
        btn1_raw = 1'b1; idle(1);
        btn1_raw = 1'b0;
        push_rep(c + 7 + LAT, c + 16 + DEB + 2);
        idle(9);
        btn1_raw = 1'b1;
        idle(15);
        total++;
        if (btn1_nivel !== 1'b0) begin
            bad++;
            $display("FAIL bounce1_nivel: nivel %b, required 0", btn1_nivel);
        end
        test_queues_empty("bounce1");
    endtask

    task automatic test_glitch0();
        btn0_raw = 1'b0;
        idle(3);
        btn0_raw = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            total++;
            if (btn0_nivel !== 1'b0) begin
                bad++;
                $display("FAIL glitch0_nivel: cycle %0d nivel %b, required 0", cyc, btn0_nivel);
            end
        end
        test_queues_empty("glitch0");
    endtask

    task automatic test_both_repeat();
        int c;
        c = cyc;
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        q0.push_back(c + LAT);
        push_rep(c + LAT, c + 40 + DEB + 2);
        idle(40);
        btn0_raw = 1'b1;
        btn1_raw = 1'b1;
        idle(15);
        test_queues_empty("both_repeat");
    endtask

    task automatic test_reset_mid_repeat();
        int c;
        int r;
        c = cyc;
        btn1_raw = 1'b0;
        push_rep(c + LAT, c + 24);
        idle(25);
        rst = 1'b0;
        #1;
        total++;
        if ({btn0, btn1, btn0_nivel, btn1_nivel} !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_outputs: outputs %b, required 0000",
                     {btn0, btn1, btn0_nivel, btn1_nivel});
        end
        test_queues_empty("pre_reset");
        idle(2);
        rst = 1'b1;
        r = cyc;
        push_rep(r + LAT, r + 25 + DEB + 2);
        idle(25);
        btn1_raw = 1'b1;
        idle(15);
        test_queues_empty("post_reset");
    endtask

    initial begin
        test_reset();
        test_press0();
        idle(5);
        test_bounce1();
        idle(5);
        test_glitch0();
        idle(5);
        test_both_repeat();
        idle(5);
        test_reset_mid_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/condiciona_botoes.md
Name: condiciona_botoes

Overview:
Front end for the clock's two push-buttons. Raw, bouncy, asynchronous pad inputs are synchronised, debounced and turned into the single-cycle press pulses that the clock's mode state machine and adjust counters consume on btn0/btn1. Channel 1, the increment button, also generates auto-repeat pulses while held, so minutes and hours can be stepped quickly. The block sits between the board pins and funcionandoRelogio.

Parameters:
DEB_CYC, 250000, consecutive stable cycles needed to accept a level change (5 ms at 50 MHz); must be >= 2.
REP_DELAY, 25000000, cycles from the press pulse to the first repeat pulse on channel 1 (0.5 s).
REP_PERIOD, 5000000, cycles between later repeat pulses on channel 1 (0.1 s).
ACTIVE_LOW, 1, 1 means a raw pin reads 0 when pressed.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn0_raw  in  1  raw mode button pin
btn1_raw  in  1  raw increment button pin
btn0  out  1  one-cycle press pulse, to the mode FSM
btn1  out  1  one-cycle press and auto-repeat pulses, to the adjust counters
btn0_nivel  out  1  debounced level, 1 = pressed
btn1_nivel  out  1  debounced level, 1 = pressed

Behaviour:
- Reset (rst=0): all flops return to the "released" state at once, independent of clk. btn0, btn1, btn0_nivel and btn1_nivel are all 0; counters are 0; repeat FSM is in SOLTO.
- Normalisation: pressed = raw XOR ACTIVE_LOW. Two-flop synchroniser per channel, reset value 0 (released).
- Debounce, per channel:
  - sync != estavel: counter increments.
  - sync == estavel: counter clears to 0. Any bounce therefore restarts the count.
  - counter == DEB_CYC-1 while sync still differs: estavel <= sync, counter <= 0.
  - btnX_nivel = estavel.
- Latency: the first clk edge that samples the new raw level is edge 1. nivel changes after edge DEB_CYC+2. The press pulse is registered and asserts for exactly one cycle after edge DEB_CYC+3. Release produces no pulse.
- A raw pulse or glitch shorter than DEB_CYC cycles produces no output change.
- Channel 0: one pulse per debounced rising edge of nivel. No repeat.
- Channel 1 repeat FSM:
  - SOLTO: on nivel rising, emit the press pulse and go to ESPERA with timer = 0.
  - ESPERA: when timer reaches REP_DELAY-1, emit a pulse, go to REPETE, timer = 0.
  - REPETE: when timer reaches REP_PERIOD-1, emit a pulse, timer = 0.
  - Any state with nivel = 0: go to SOLTO, timer = 0, no pulse. Release wins over a timer match in the same cycle.
  - Result: pulse spacing is REP_DELAY cycles from the press pulse to the first repeat, then REP_PERIOD cycles between repeats.
- Counter widths are $clog2 of the respective parameter. Counters saturate only through the compare-and-clear above; they never wrap silently.
- Channels are independent. Simultaneous presses give simultaneous pulses; no priority is applied.
- A button held through reset deassertion produces one press pulse DEB_CYC+3 cycles after release of reset. Channel 1 then repeats normally.
- Pulse outputs are never high in two consecutive cycles, since REP_PERIOD >= 2 is required.

Decomposition:
- Shared package relogio_pkg holds:
  - repeat-FSM state encodings SOLTO=2'b00, ESPERA=2'b01, REPETE=2'b10;
  - 50 MHz default timing constants;
  - button polarity constant.
- Sub-module canal_botao: synchroniser, debounce, edge pulse and optional repeat, selected by parameter REPEAT_EN. It is instantiated twice: channel 0 with REPEAT_EN=0, channel 1 with REPEAT_EN=1.
- The top level contains only the polarity XOR and the two instances.

Test Plan (bench overrides DEB_CYC=4, REP_DELAY=10, REP_PERIOD=3, ACTIVE_LOW=1):
1. Raw pins at 1, rst=0 held for 3 cycles, then released -> all four outputs are 0 throughout and stay 0 for 50 cycles.
2. btn0_raw 1->0, held for 20 cycles -> btn0_nivel=1 after edge 6; a single btn0 pulse after edge 7; raw back to 1 -> nivel=0 six edges later with no pulse.
3. btn1_raw low for 3 cycles, high for 1, low for 2, high for 1, then low steadily -> exactly one btn1 pulse, 7 edges after the last 1->0 transition is sampled.
4. btn0_raw low for 3 cycles, then high -> btn0 and btn0_nivel remain 0.
5. btn0_raw and btn1_raw held low for 40 cycles together -> both pulse at press edge t0. btn1 then pulses at t0+10, t0+13, t0+16, …, while btn0 pulses only once. On release, btn1 pulses stop.
6. rst=0 asserted mid-repeat while btn1_raw is still low -> outputs go to 0 immediately. After rst=1, one btn1 pulse follows after 7 edges, then repeats resume at +10, +3, +3.
